// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter sharing one cache between two CPU ports.
// Defining ARB_TIMEOUT_EN adds a watchdog on cache completion (TIMEOUT cycles).
module cache_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [21:0] p0_req,
   input  logic        p0_valid,
   input  logic [21:0] p1_req,
   input  logic        p1_valid,
   output logic        p0_ack,
   output logic        p1_ack,
   output logic [21:0] cache_req,
   output logic        cache_req_valid,
   input  logic        cache_done,
   input  logic [21:0] cache_data,
   output logic [21:0] resp_data,
   output logic        p0_resp_valid,
   output logic        p1_resp_valid,
   output logic        busy,
   output logic        err
);

   localparam int unsigned REQ_W = 22;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

   state_t           state_q, state_d;
   logic [REQ_W-1:0] req_q, req_d;
   logic             last_grant_q, last_grant_d;
   logic             p0_ack_q, p0_ack_d;
   logic             p1_ack_q, p1_ack_d;
   logic [REQ_W-1:0] cache_req_q, cache_req_d;
   logic             cache_req_valid_q, cache_req_valid_d;
   logic [REQ_W-1:0] resp_data_q, resp_data_d;
   logic             p0_resp_valid_q, p0_resp_valid_d;
   logic             p1_resp_valid_q, p1_resp_valid_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic             grant_c;
   logic             timeout_c;

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Watchdog counts WAIT cycles; cleared on the way into WAIT.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ISSUE) begin
         cnt_d = '0;
      end else if (state_q == WAIT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   assign timeout_c = (state_q == WAIT) && (cnt_d == CNT_W'(TIMEOUT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_c = 1'b0;
`endif

   // Next state and registered outputs; outputs trail the state by one cycle.
   always_comb begin
      state_d           = state_q;
      req_d             = req_q;
      last_grant_d      = last_grant_q;
      p0_ack_d          = 1'b0;
      p1_ack_d          = 1'b0;
      cache_req_d       = cache_req_q;
      cache_req_valid_d = 1'b0;
      resp_data_d       = resp_data_q;
      p0_resp_valid_d   = 1'b0;
      p1_resp_valid_d   = 1'b0;
      busy_d            = (state_q != IDLE);
      err_d             = err_q;
      grant_c           = 1'b0;

      case (state_q)
         IDLE: begin
            if (p0_valid || p1_valid) begin
               // Tie goes to the port that did not win last time.
               grant_c      = (p0_valid && p1_valid) ? ~last_grant_q : p1_valid;
               req_d        = grant_c ? p1_req : p0_req;
               req_d[21]    = grant_c;
               last_grant_d = grant_c;
               p0_ack_d     = ~grant_c;
               p1_ack_d     = grant_c;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            cache_req_d       = req_q;
            cache_req_valid_d = 1'b1;
            state_d           = WAIT;
         end
         WAIT: begin
            if (cache_done) begin
               resp_data_d = cache_data;
               if (cache_data[21] != last_grant_q) begin
                  err_d = 1'b1;
               end
               state_d = RESPOND;
            end else if (timeout_c) begin
               resp_data_d = '0;
               err_d       = 1'b1;
               state_d     = RESPOND;
            end
         end
         RESPOND: begin
            p0_resp_valid_d = ~last_grant_q;
            p1_resp_valid_d = last_grant_q;
            state_d         = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (cache_done && (state_q != WAIT)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= IDLE;
         req_q             <= '0;
         last_grant_q      <= 1'b1;
         p0_ack_q          <= 1'b0;
         p1_ack_q          <= 1'b0;
         cache_req_q       <= '0;
         cache_req_valid_q <= 1'b0;
         resp_data_q       <= '0;
         p0_resp_valid_q   <= 1'b0;
         p1_resp_valid_q   <= 1'b0;
         busy_q            <= 1'b0;
         err_q             <= 1'b0;
      end else begin
         state_q           <= state_d;
         req_q             <= req_d;
         last_grant_q      <= last_grant_d;
         p0_ack_q          <= p0_ack_d;
         p1_ack_q          <= p1_ack_d;
         cache_req_q       <= cache_req_d;
         cache_req_valid_q <= cache_req_valid_d;
         resp_data_q       <= resp_data_d;
         p0_resp_valid_q   <= p0_resp_valid_d;
         p1_resp_valid_q   <= p1_resp_valid_d;
         busy_q            <= busy_d;
         err_q             <= err_d;
      end
   end

   assign p0_ack          = p0_ack_q;
   assign p1_ack          = p1_ack_q;
   assign cache_req       = cache_req_q;
   assign cache_req_valid = cache_req_valid_q;
   assign resp_data       = resp_data_q;
   assign p0_resp_valid   = p0_resp_valid_q;
   assign p1_resp_valid   = p1_resp_valid_q;
   assign busy            = busy_q;
   assign err             = err_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter; covers the ARB_TIMEOUT_EN build when defined.
module tb_cache_arbiter;

   logic        clk;
   logic        reset;
   logic [21:0] p0_req;
   logic        p0_valid;
   logic [21:0] p1_req;
   logic        p1_valid;
   logic        p0_ack;
   logic        p1_ack;
   logic [21:0] cache_req;
   logic        cache_req_valid;
   logic        cache_done;
   logic [21:0] cache_data;
   logic [21:0] resp_data;
   logic        p0_resp_valid;
   logic        p1_resp_valid;
   logic        busy;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   localparam logic [21:0] P0A     = 22'b0_0_01011010000_0_00000000;
   localparam logic [21:0] P1A     = 22'b0_1_01010000000_1_11111111;
   localparam logic [21:0] P1A_EXP = 22'b1_1_01010000000_1_11111111;

   cache_arbiter #(.TIMEOUT(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .p0_req          (p0_req),
      .p0_valid        (p0_valid),
      .p1_req          (p1_req),
      .p1_valid        (p1_valid),
      .p0_ack          (p0_ack),
      .p1_ack          (p1_ack),
      .cache_req       (cache_req),
      .cache_req_valid (cache_req_valid),
      .cache_done      (cache_done),
      .cache_data      (cache_data),
      .resp_data       (resp_data),
      .p0_resp_valid   (p0_resp_valid),
      .p1_resp_valid   (p1_resp_valid),
      .busy            (busy),
      .err             (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_p0_ack"}, p0_ack, 0);
      chk({tag, "_p1_ack"}, p1_ack, 0);
      chk({tag, "_crv"}, cache_req_valid, 0);
      chk({tag, "_cache_req"}, cache_req, 0);
      chk({tag, "_resp_data"}, resp_data, 0);
      chk({tag, "_p0_rv"}, p0_resp_valid, 0);
      chk({tag, "_p1_rv"}, p1_resp_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   initial begin
      reset      = 1'b0;
      p0_req     = '0;
      p0_valid   = 1'b0;
      p1_req     = '0;
      p1_valid   = 1'b0;
      cache_done = 1'b0;
      cache_data = '0;
      tick();
      tick();
      chk_idle_outputs("rst");

      // Both ports request in the first cycle after reset: P0 wins the tie
      reset    = 1'b1;
      p0_req   = P0A;
      p0_valid = 1'b1;
      p1_req   = P1A;
      p1_valid = 1'b1;
      tick();
      chk("tie_p0_ack", p0_ack, 1);
      chk("tie_p1_ack", p1_ack, 0);
      chk("ack_busy", busy, 0);
      p0_valid = 1'b0;
      tick();
      chk("p0_crv", cache_req_valid, 1);
      chk("p0_cache_req", cache_req, P0A);
      chk("p0_issue_busy", busy, 1);
      tick();
      chk("p0_crv_one_cycle", cache_req_valid, 0);
      cache_done = 1'b1;
      cache_data = 22'h0123AB;
      tick();
      cache_done = 1'b0;
      chk("p0_rv_early", p0_resp_valid, 0);
      tick();
      chk("p0_rv", p0_resp_valid, 1);
      chk("p0_no_p1_rv", p1_resp_valid, 0);
      chk("p0_resp_data", resp_data, 22'h0123AB);
      chk("p0_err", err, 0);
      chk("respond_busy", busy, 1);

      // P1 held its request; granted from the IDLE cycle after P0's RESPOND
      tick();
      chk("p1_ack", p1_ack, 1);
      chk("p0_rv_pulse", p0_resp_valid, 0);
      chk("idle_busy", busy, 0);
      p1_valid = 1'b0;
      tick();
      chk("p1_crv", cache_req_valid, 1);
      chk("p1_cache_req_id", cache_req[21], 1);
      chk("p1_cache_req", cache_req, P1A_EXP);
      tick();
      chk("p1_wait_busy", busy, 1);
      cache_done = 1'b1;
      cache_data = 22'h2000AB;
      tick();
      cache_done = 1'b0;
      tick();
      chk("p1_rv", p1_resp_valid, 1);
      chk("p1_no_p0_rv", p0_resp_valid, 0);
      chk("p1_resp_data", resp_data, 22'h2000AB);
      chk("p1_err", err, 0);

      // Re-request from both: last_grant is P1, so P0 wins again
      p0_valid = 1'b1;
      p1_valid = 1'b1;
      tick();
      chk("rr_p0_ack", p0_ack, 1);
      chk("rr_p1_ack", p1_ack, 0);
      p0_valid = 1'b0;
      tick();
      tick();
      cache_done = 1'b1;
      cache_data = 22'h3000CD;
      tick();
      cache_done = 1'b0;
      chk("bad_id_err", err, 1);
      tick();
      chk("bad_id_p0_rv", p0_resp_valid, 1);
      chk("bad_id_p1_rv", p1_resp_valid, 0);
      chk("bad_id_resp_data", resp_data, 22'h3000CD);
      chk("bad_id_err_sticky", err, 1);
      tick();
      chk("rr_p1_ack", p1_ack, 1);
      p1_valid = 1'b0;
      tick();
      tick();
      cache_done = 1'b1;
      cache_data = 22'h200011;
      tick();
      cache_done = 1'b0;
      tick();
      chk("rr_p1_rv", p1_resp_valid, 1);
      chk("err_still_set", err, 1);

      // Reset while waiting on the cache aborts the transaction
      p0_req   = 22'h05A5A5;
      p0_valid = 1'b1;
      tick();
      chk("abort_p0_ack", p0_ack, 1);
      p0_valid = 1'b0;
      tick();
      tick();
      chk("abort_wait_busy", busy, 1);
      reset = 1'b0;
      #1;
      chk_idle_outputs("async_rst");
      tick();
      reset    = 1'b1;
      p1_req   = 22'h1ABCDE;
      p1_valid = 1'b1;
      tick();
      chk("post_rst_p1_ack", p1_ack, 1);
      chk("post_rst_p0_ack", p0_ack, 0);
      p1_valid = 1'b0;
      tick();
      chk("post_rst_crv", cache_req_valid, 1);
      chk("post_rst_cache_req", cache_req, 22'h3ABCDE);
      tick();
      cache_done = 1'b1;
      cache_data = 22'h2000EE;
      tick();
      cache_done = 1'b0;
      tick();
      chk("post_rst_p1_rv", p1_resp_valid, 1);
      chk("post_rst_p0_rv", p0_resp_valid, 0);
      chk("post_rst_resp_data", resp_data, 22'h2000EE);
      chk("post_rst_err", err, 0);

      // Stray completion while IDLE
      cache_done = 1'b1;
      cache_data = 22'h000055;
      tick();
      cache_done = 1'b0;
      chk("stray_done_err", err, 1);
      chk("stray_done_busy", busy, 0);
      chk("stray_done_p0_rv", p0_resp_valid, 0);
      chk("stray_done_p1_rv", p1_resp_valid, 0);
      tick();
      chk("stray_err_sticky", err, 1);

      // Cache never completes (watchdog build) or completes very late
      p0_req   = P0A;
      p0_valid = 1'b1;
      tick();
      chk("late_p0_ack", p0_ack, 1);
      p0_valid = 1'b0;
      tick();
      chk("late_crv", cache_req_valid, 1);
`ifdef ARB_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         tick();
      end
      chk("to_rv_early", p0_resp_valid, 0);
      tick();
      chk("to_p0_rv", p0_resp_valid, 1);
      chk("to_resp_data", resp_data, 22'h000000);
      chk("to_err", err, 1);
      tick();
      chk("to_idle_busy", busy, 0);
      chk("to_rv_pulse", p0_resp_valid, 0);
`else
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      chk("late_no_rv", p0_resp_valid, 0);
      chk("late_busy", busy, 1);
      cache_done = 1'b1;
      cache_data = 22'h000777;
      tick();
      cache_done = 1'b0;
      tick();
      chk("late_p0_rv", p0_resp_valid, 1);
      chk("late_p1_rv", p1_resp_valid, 0);
      chk("late_resp_data", resp_data, 22'h000777);
      chk("late_err", err, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
